// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: width, reset PC, FSM states
// and the buffered {pc, instr} entry.
package fetch_pkg;

   localparam int                XLEN     = 32;
   localparam logic [XLEN-1:0]   RESET_PC = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO of fetch entries. flush wins over push and pop;
// a push on a full FIFO is only taken when a pop frees the slot that cycle.
module ifu_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output fetch_entry_t             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   assign head      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is cleared on reset so head never shows X to decode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, buffers {pc, instr} words for decode,
// applies redirects and halts on an all-zero instruction word.
module instr_fetch_ctrl #(
   parameter int                     XLEN       = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0]        RESET_PC   = fetch_pkg::RESET_PC,
   parameter int                     FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fetch_en,
   output logic [XLEN-1:0]           imem_addr,
   input  logic [XLEN-1:0]           imem_rdata,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           out_pc,
   output logic [XLEN-1:0]           out_instr,
   output logic                      halted,
   output logic [31:0]               fetch_count,
   output fetch_pkg::fetch_state_e   dbg_state
);

   import fetch_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Handshake: decode takes the head entry on any rising edge where
   // out_valid & out_ready; out_valid is forced low during a redirect.

   fetch_state_e     r_state;
   fetch_state_e     w_state_nxt;
   logic [XLEN-1:0]  r_pc;
   logic [31:0]      r_fetch_count;

   logic [CW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;
   fetch_entry_t     w_head;
   fetch_entry_t     w_push_data;
   logic             w_pop;
   logic             w_fetch_slot;
   logic             w_push;
   logic             w_illegal;

   assign w_pop        = out_ready & ~w_empty & ~redirect_valid;
   assign w_fetch_slot = (r_state == RUN) & ~redirect_valid & (~w_full | w_pop);
   assign w_illegal    = (imem_rdata == '0);
   assign w_push       = w_fetch_slot & ~w_illegal;
   assign w_push_data  = '{pc: r_pc, instr: imem_rdata};

   ifu_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (w_push),
      .push_data  (w_push_data),
      .pop        (w_pop),
      .flush      (redirect_valid),
      .count      (w_count),
      .full       (w_full),
      .empty      (w_empty),
      .head       (w_head)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = fetch_en ? RUN : IDLE;
      end else begin
         case (r_state)
            IDLE:    if (fetch_en) w_state_nxt = RUN;
            RUN: begin
               if (!fetch_en)                      w_state_nxt = IDLE;
               else if (w_fetch_slot && w_illegal) w_state_nxt = HALT;
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_fetch_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect_valid) begin
            r_pc <= redirect_pc & ~XLEN'(3);
         end else if (w_push) begin
            r_pc <= r_pc + XLEN'(4);
         end
         if (w_push) r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign imem_addr   = r_pc;
   assign out_valid   = (w_count != '0) & ~redirect_valid;
   assign out_pc      = w_head.pc;
   assign out_instr   = w_head.instr;
   assign halted      = (r_state == HALT);
   assign fetch_count = r_fetch_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: memory model, pop scoreboard and
// hand-computed checks of PC, FIFO, halt, redirect and reset behaviour.
module tb_instr_fetch_ctrl;
   import fetch_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_en;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [31:0]   out_instr;
   logic          halted;
   logic [31:0]   fetch_count;
   fetch_state_e  dbg_state;

   logic [31:0]   mem [0:15];
   logic [63:0]   exp_q [$];
   int            n_checks = 0;
   int            n_fail   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   instr_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .halted         (halted),
      .fetch_count    (fetch_count),
      .dbg_state      (dbg_state)
   );

   // Words 0x00..0x3C come from mem[]; every other address reads 0x00000013.
   always_comb begin
      if (imem_addr[31:6] == '0) imem_rdata = mem[imem_addr[5:2]];
      else                       imem_rdata = 32'h0000_0013;
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every completed handshake must match the next expected entry.
   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check_eq("pop_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check_eq("pop_entry", {out_pc, out_instr}, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic redirect_to(input logic [31:0] target, input logic rdy);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      out_ready      = rdy;
      wait_neg(1);
      redirect_valid = 1'b0;
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'hFFC4_A303;
      mem[1] = 32'h0064_A423;
      mem[2] = 32'h0062_E233;
      mem[3] = 32'hFE42_0AE3;
      mem[5] = 32'h00A0_0093;

      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      wait_neg(3);

      check_eq("rst_addr",   imem_addr,   64'h0);
      check_eq("rst_valid",  out_valid,   64'd0);
      check_eq("rst_halted", halted,      64'd0);
      check_eq("rst_count",  fetch_count, 64'd0);
      check_eq("rst_head",   {out_pc, out_instr}, 64'h0);
      check_eq("rst_state",  dbg_state,   64'(IDLE));

      // Stream 0..C, then the zero word at 0x10 halts the sequencer.
      exp_q.push_back({32'h0, 32'hFFC4_A303});
      exp_q.push_back({32'h4, 32'h0064_A423});
      exp_q.push_back({32'h8, 32'h0062_E233});
      exp_q.push_back({32'hC, 32'hFE42_0AE3});
      rst_n     = 1'b1;
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      wait_neg(1);
      check_eq("t1_idle_addr",  imem_addr, 64'h0);
      check_eq("t1_idle_valid", out_valid, 64'd0);
      check_eq("t1_run_state",  dbg_state, 64'(RUN));
      wait_neg(1);
      check_eq("t1_lat_valid",  out_valid, 64'd1);
      check_eq("t1_lat_pc",     out_pc,    64'h0);
      check_eq("t1_lat_addr",   imem_addr, 64'h4);
      wait_neg(3);
      check_eq("t1_pre_halt",   halted,      64'd0);
      check_eq("t1_count",      fetch_count, 64'd4);
      wait_neg(1);
      check_eq("t4_halted",     halted,      64'd1);
      check_eq("t4_count",      fetch_count, 64'd4);
      check_eq("t4_addr",       imem_addr,   64'h10);
      check_eq("t1_drained",    exp_q.size(), 64'd0);
      wait_neg(3);
      check_eq("t4_halt_hold",  halted,      64'd1);
      check_eq("t4_count_hold", fetch_count, 64'd4);

      // Resume from 0 with decode stalled: FIFO fills, PC parks at 8.
      redirect_to(32'h0, 1'b0);
      check_eq("t4_resume_halt", halted,    64'd0);
      check_eq("t4_resume_addr", imem_addr, 64'h0);
      wait_neg(5);
      check_eq("t2_stall_addr",  imem_addr,   64'h8);
      check_eq("t2_stall_pc",    out_pc,      64'h0);
      check_eq("t2_stall_valid", out_valid,   64'd1);
      check_eq("t2_stall_count", fetch_count, 64'd6);
      exp_q.push_back({32'h0, 32'hFFC4_A303});
      exp_q.push_back({32'h4, 32'h0064_A423});
      exp_q.push_back({32'h8, 32'h0062_E233});
      exp_q.push_back({32'hC, 32'hFE42_0AE3});
      out_ready = 1'b1;
      wait_neg(6);
      check_eq("t2_drained", exp_q.size(), 64'd0);
      check_eq("t2_count",   fetch_count,  64'd8);
      check_eq("t2_halted",  halted,       64'd1);

      // Redirect to 0x16 with two stale entries buffered.
      redirect_to(32'h0, 1'b0);
      wait_neg(2);
      check_eq("t3_full_valid", out_valid,   64'd1);
      check_eq("t3_full_addr",  imem_addr,   64'h8);
      check_eq("t3_full_count", fetch_count, 64'd10);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h16;
      out_ready      = 1'b1;
      #1;
      check_eq("t3_redir_valid", out_valid, 64'd0);
      exp_q.push_back({32'h14, 32'h00A0_0093});
      wait_neg(1);
      redirect_valid = 1'b0;
      #1;
      check_eq("t3_new_addr",  imem_addr, 64'h14);
      check_eq("t3_flushed",   out_valid, 64'd0);
      wait_neg(4);
      check_eq("t3_drained",   exp_q.size(), 64'd0);
      check_eq("t3_halted",    halted,       64'd1);
      check_eq("t3_count",     fetch_count,  64'd11);

      // PC wrap from 0xFFFFFFFC to 0.
      redirect_to(32'hFFFF_FFFC, 1'b0);
      check_eq("t5_addr_top", imem_addr, 64'hFFFF_FFFC);
      wait_neg(3);
      check_eq("t5_addr_wrap", imem_addr,   64'h4);
      check_eq("t5_head_pc",   out_pc,      64'hFFFF_FFFC);
      check_eq("t5_head_ins",  out_instr,   64'h0000_0013);
      check_eq("t5_count",     fetch_count, 64'd13);
      exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0013});
      out_ready = 1'b1;
      wait_neg(1);
      out_ready = 1'b0;
      check_eq("t5_wrap_pc",   out_pc,      64'h0);
      check_eq("t5_wrap_ins",  out_instr,   64'hFFC4_A303);
      check_eq("t5_count2",    fetch_count, 64'd14);
      check_eq("t5_addr2",     imem_addr,   64'h8);

      // Reset with a full FIFO and a simultaneous redirect.
      rst_n          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      wait_neg(1);
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      #1;
      check_eq("t6_addr",   imem_addr,   64'h0);
      check_eq("t6_valid",  out_valid,   64'd0);
      check_eq("t6_halted", halted,      64'd0);
      check_eq("t6_count",  fetch_count, 64'd0);
      check_eq("t6_state",  dbg_state,   64'(IDLE));
      wait_neg(2);
      check_eq("t6_idle_addr",  imem_addr, 64'h0);
      check_eq("t6_idle_valid", out_valid, 64'd0);
      check_eq("final_queue",   exp_q.size(), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
